// File: rtl/mem_pkg.sv
// Shared constants and helpers for the four-bank memory responder.
package mem_pkg;

    localparam int unsigned NUM_BANKS    = 4;
    localparam int unsigned BANK_SEL_LSB = 1;
    localparam int unsigned BANK_SEL_W   = 2;
    localparam int unsigned WORD_LSB     = 3;
    localparam int unsigned DATA_W       = 16;

    localparam int unsigned DEF_AW       = 16;
    localparam int unsigned DEF_BANK_LAT = 4;
    localparam int unsigned DEF_RD_LAT   = 2;

    typedef logic [DATA_W-1:0] word_t;

    // Bits needed for a down-counter that is loaded with lat and counts to zero
    function automatic int unsigned busy_cnt_w(input int unsigned lat);
        return (lat < 2) ? 1 : $clog2(lat + 1);
    endfunction

endpackage

// File: rtl/four_bank_mem_resp_if.sv
// Request/response bus between the cache FSM (master) and the memory responder (slave).
interface four_bank_mem_resp_if
    import mem_pkg::*;
#(
    parameter int unsigned AW = DEF_AW
);

    logic [AW-1:0]        addr;
    word_t                data_in;
    logic                 wr;
    logic                 rd;
    word_t                data_out;
    logic [NUM_BANKS-1:0] busy;
    logic                 stall;
    logic                 err;

    modport master (
        output addr, data_in, wr, rd,
        input  data_out, busy, stall, err
    );

    modport slave (
        input  addr, data_in, wr, rd,
        output data_out, busy, stall, err
    );

endinterface

// File: rtl/mem_bank.sv
// One memory bank: word array, write port, read capture register and busy window counter.
module mem_bank
    import mem_pkg::*;
#(
    parameter int unsigned WORD_W   = 13,
    parameter int unsigned BANK_LAT = DEF_BANK_LAT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_acc_i,
    input  logic              rd_acc_i,
    input  logic [WORD_W-1:0] word_i,
    input  word_t             wdata_i,
    output word_t             rdata_o,
    output logic              busy_o
);

    localparam int unsigned CntW  = busy_cnt_w(BANK_LAT);
    localparam int unsigned Depth = 2 ** WORD_W;

    word_t           mem_q [Depth];
    word_t           rdata_q;
    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_d;

    // Array write port; contents are deliberately left unreset
    always_ff @(posedge clk) begin
        if (wr_acc_i) begin
            mem_q[word_i] <= wdata_i;
        end
    end

    // Read capture: first stage of the read pipeline lives next to the array
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (rd_acc_i) begin
            rdata_q <= mem_q[word_i];
        end
    end

    // Busy window: reload on any accept, otherwise count down to zero
    always_comb begin
        cnt_d = cnt_q;
        if (wr_acc_i || rd_acc_i) begin
            cnt_d = CntW'(BANK_LAT);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CntW'(1);
        end
    end

    // Busy counter state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign rdata_o = rdata_q;
    assign busy_o  = (cnt_q != '0);

endmodule

// File: rtl/four_bank_mem_resp.sv
// Four-bank word-interleaved memory responder for the cache fm_*/m_* interface.
// Bank = addr[2:1], word = addr[AW-1:3]. Fixed two-cycle read latency.
// Optional: define MEM_ALIGN_CHECK_EN to flag odd (unaligned) addresses as errors.
module four_bank_mem_resp
    import mem_pkg::*;
#(
    parameter int unsigned AW       = DEF_AW,
    parameter int unsigned BANK_LAT = DEF_BANK_LAT,
    parameter int unsigned RD_LAT   = DEF_RD_LAT
) (
    input logic                 clk,
    input logic                 rst,
    four_bank_mem_resp_if.slave bus
);

    localparam int unsigned WordW = AW - WORD_LSB;

    if (RD_LAT != 2) begin : g_bad_rd_lat
        $error("four_bank_mem_resp: only RD_LAT == 2 is supported");
    end
    if (BANK_LAT < 1) begin : g_bad_bank_lat
        $error("four_bank_mem_resp: BANK_LAT must be at least 1");
    end

    logic                  req;
    logic                  err;
    logic                  stall;
    logic                  accept;
    logic [BANK_SEL_W-1:0] bank_sel;
    logic [WordW-1:0]      word;
    logic [NUM_BANKS-1:0]  busy;
    logic [NUM_BANKS-1:0]  wr_acc;
    logic [NUM_BANKS-1:0]  rd_acc;
    word_t                 rdata [NUM_BANKS];

    logic                  s1_valid_q;
    logic [BANK_SEL_W-1:0] s1_bank_q;
    logic                  s2_valid_q;
    word_t                 s2_data_q;

`ifndef MEM_ALIGN_CHECK_EN
    logic unused_addr0;
    assign unused_addr0 = bus.addr[0];
`endif

    // Request decode and accept/stall/err qualification
    always_comb begin
        req      = bus.rd | bus.wr;
        bank_sel = bus.addr[BANK_SEL_LSB +: BANK_SEL_W];
        word     = bus.addr[WORD_LSB +: WordW];
`ifdef MEM_ALIGN_CHECK_EN
        err      = (bus.rd & bus.wr) | (req & bus.addr[0]);
`else
        err      = bus.rd & bus.wr;
`endif
        // err takes priority so an illegal request never reports stall
        stall    = req & ~err & busy[bank_sel];
        accept   = req & ~err & ~stall;
    end

    // Per-bank accept strobes
    always_comb begin
        wr_acc = '0;
        rd_acc = '0;
        if (accept) begin
            wr_acc[bank_sel] = bus.wr;
            rd_acc[bank_sel] = bus.rd;
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        mem_bank #(
            .WORD_W   (WordW),
            .BANK_LAT (BANK_LAT)
        ) u_bank (
            .clk      (clk),
            .rst      (rst),
            .wr_acc_i (wr_acc[b]),
            .rd_acc_i (rd_acc[b]),
            .word_i   (word),
            .wdata_i  (bus.data_in),
            .rdata_o  (rdata[b]),
            .busy_o   (busy[b])
        );
    end

    // Read pipeline: stage1 tracks which bank captured, stage2 holds the returned word.
    // The capturing bank is busy for at least one cycle, so its capture register is stable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_bank_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
        end else begin
            s1_valid_q <= accept & bus.rd;
            if (accept && bus.rd) begin
                s1_bank_q <= bank_sel;
            end
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_data_q <= rdata[s1_bank_q];
            end
        end
    end

    // Response outputs; data_out is forced to zero outside a valid return cycle
    always_comb begin
        bus.data_out = s2_valid_q ? s2_data_q : '0;
        bus.busy     = busy;
        bus.stall    = stall;
        bus.err      = err;
    end

endmodule

// File: tb/tb_four_bank_mem_resp.sv
// Directed self-checking bench for four_bank_mem_resp.
// Honours MEM_ALIGN_CHECK_EN for the unaligned-address scenario.
module tb_four_bank_mem_resp;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    four_bank_mem_resp_if #(.AW(16)) bus ();

    four_bank_mem_resp #(
        .AW       (16),
        .BANK_LAT (4),
        .RD_LAT   (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Step to just after the next rising edge
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Apply one request for the current cycle and let combinational outputs settle
    task automatic drive(input logic r, input logic w, input logic [15:0] a,
                         input logic [15:0] d);
        bus.rd      = r;
        bus.wr      = w;
        bus.addr    = a;
        bus.data_in = d;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 16'h0000, 16'h0000);
    endtask

    task automatic test_reset();
        #2;
        total++; if (bus.busy !== 4'b0000) begin bad++; $display("FAIL rst_busy got=%b exp=%b", bus.busy, 4'b0000); end
        total++; if (bus.data_out !== 16'h0000) begin bad++; $display("FAIL rst_data got=%h exp=%h", bus.data_out, 16'h0000); end
        total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL rst_stall got=%b exp=0", bus.stall); end
        total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", bus.err); end
        next_cycle();
        rst = 1'b0;
        idle();
        next_cycle();
        drive(1'b1, 1'b0, 16'h0100, 16'h0000);
        total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL rst_rd_stall got=%b exp=0", bus.stall); end
        next_cycle();
        idle();
        total++; if (bus.busy !== 4'b0001) begin bad++; $display("FAIL rst_pre_busy got=%b exp=%b", bus.busy, 4'b0001); end
        // Asynchronous reset while the read is in flight
        rst = 1'b1;
        #1;
        total++; if (bus.busy !== 4'b0000) begin bad++; $display("FAIL rst_mid_busy got=%b exp=%b", bus.busy, 4'b0000); end
        total++; if (bus.data_out !== 16'h0000) begin bad++; $display("FAIL rst_mid_data got=%h exp=0000", bus.data_out); end
        next_cycle();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            total++; if (bus.data_out !== 16'h0000) begin bad++; $display("FAIL rst_no_data k=%0d got=%h exp=0000", k, bus.data_out); end
            next_cycle();
        end
    endtask

    task automatic test_write_read();
        drive(1'b0, 1'b1, 16'h0010, 16'hBEEF);
        total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL wr_stall got=%b exp=0", bus.stall); end
        for (int k = 1; k <= 4; k++) begin
            next_cycle();
            idle();
            total++; if (bus.busy !== 4'b0001) begin bad++; $display("FAIL wr_busy k=%0d got=%b exp=0001", k, bus.busy); end
        end
        next_cycle();
        drive(1'b1, 1'b0, 16'h0010, 16'h0000);
        total++; if (bus.busy !== 4'b0000) begin bad++; $display("FAIL wr_busy_end got=%b exp=0000", bus.busy); end
        total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL rd_stall got=%b exp=0", bus.stall); end
        for (int k = 1; k <= 5; k++) begin
            logic [15:0] exp_d;
            logic [3:0]  exp_b;
            next_cycle();
            idle();
            exp_d = (k == 2) ? 16'hBEEF : 16'h0000;
            exp_b = (k <= 4) ? 4'b0001 : 4'b0000;
            total++; if (bus.data_out !== exp_d) begin bad++; $display("FAIL rd_data k=%0d got=%h exp=%h", k, bus.data_out, exp_d); end
            total++; if (bus.busy !== exp_b) begin bad++; $display("FAIL rd_busy k=%0d got=%b exp=%b", k, bus.busy, exp_b); end
        end
    endtask

    task automatic test_line_fill();
        logic [15:0] fill [4];
        fill[0] = 16'h1111;
        fill[1] = 16'h2222;
        fill[2] = 16'h3333;
        fill[3] = 16'h4444;
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            drive(1'b0, 1'b1, 16'h0020 + 16'(2 * i), fill[i]);
            total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL fill_wr_stall i=%0d got=%b exp=0", i, bus.stall); end
        end
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            idle();
        end
        for (int k = 0; k < 8; k++) begin
            logic [15:0] exp_d;
            next_cycle();
            if (k < 4) drive(1'b1, 1'b0, 16'h0020 + 16'(2 * k), 16'h0000);
            else idle();
            exp_d = (k >= 2 && k < 6) ? fill[k-2] : 16'h0000;
            if (k < 4) begin
                total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL fill_rd_stall k=%0d got=%b exp=0", k, bus.stall); end
            end
            if (k == 3) begin
                total++; if (bus.busy !== 4'b0111) begin bad++; $display("FAIL fill_busy got=%b exp=0111", bus.busy); end
            end
            total++; if (bus.data_out !== exp_d) begin bad++; $display("FAIL fill_data k=%0d got=%h exp=%h", k, bus.data_out, exp_d); end
        end
    endtask

    task automatic test_conflict();
        next_cycle();
        drive(1'b0, 1'b1, 16'h0038, 16'h7777);
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            idle();
        end
        next_cycle();
        drive(1'b0, 1'b1, 16'h0030, 16'h5A5A);
        total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL cf_wr_stall got=%b exp=0", bus.stall); end
        // Same-bank read held while bank 0 is in its busy window
        for (int k = 1; k <= 4; k++) begin
            next_cycle();
            drive(1'b1, 1'b0, 16'h0038, 16'h0000);
            total++; if (bus.stall !== 1'b1) begin bad++; $display("FAIL cf_stall k=%0d got=%b exp=1", k, bus.stall); end
        end
        next_cycle();
        drive(1'b1, 1'b0, 16'h0038, 16'h0000);
        total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL cf_accept got=%b exp=0", bus.stall); end
        for (int k = 1; k <= 5; k++) begin
            logic [15:0] exp_d;
            next_cycle();
            idle();
            exp_d = (k == 2) ? 16'h7777 : 16'h0000;
            total++; if (bus.busy[0] !== (k <= 4)) begin bad++; $display("FAIL cf_busy k=%0d got=%b exp=%b", k, bus.busy[0], (k <= 4)); end
            total++; if (bus.data_out !== exp_d) begin bad++; $display("FAIL cf_data k=%0d got=%h exp=%h", k, bus.data_out, exp_d); end
        end
    endtask

    task automatic test_err();
        next_cycle();
        drive(1'b0, 1'b1, 16'h0040, 16'h1234);
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            idle();
        end
        next_cycle();
        drive(1'b1, 1'b1, 16'h0040, 16'hDEAD);
        total++; if (bus.err !== 1'b1) begin bad++; $display("FAIL err_set got=%b exp=1", bus.err); end
        total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL err_stall got=%b exp=0", bus.stall); end
        next_cycle();
        drive(1'b1, 1'b0, 16'h0040, 16'h0000);
        total++; if (bus.busy !== 4'b0000) begin bad++; $display("FAIL err_busy got=%b exp=0000", bus.busy); end
        total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL err_clear got=%b exp=0", bus.err); end
        next_cycle();
        // Illegal request against a busy bank reports err, never stall
        drive(1'b1, 1'b1, 16'h0040, 16'hDEAD);
        total++; if (bus.err !== 1'b1) begin bad++; $display("FAIL err_busy_bank got=%b exp=1", bus.err); end
        total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL err_busy_stall got=%b exp=0", bus.stall); end
        next_cycle();
        idle();
        total++; if (bus.data_out !== 16'h1234) begin bad++; $display("FAIL err_array got=%h exp=1234", bus.data_out); end
    endtask

    task automatic test_align();
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            idle();
        end
        next_cycle();
        drive(1'b1, 1'b0, 16'h0011, 16'h0000);
`ifdef MEM_ALIGN_CHECK_EN
        total++; if (bus.err !== 1'b1) begin bad++; $display("FAIL al_err got=%b exp=1", bus.err); end
        next_cycle();
        idle();
        total++; if (bus.busy !== 4'b0000) begin bad++; $display("FAIL al_busy got=%b exp=0000", bus.busy); end
        next_cycle();
        idle();
        total++; if (bus.data_out !== 16'h0000) begin bad++; $display("FAIL al_data got=%h exp=0000", bus.data_out); end
`else
        total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL al_err got=%b exp=0", bus.err); end
        next_cycle();
        idle();
        total++; if (bus.busy !== 4'b0001) begin bad++; $display("FAIL al_busy got=%b exp=0001", bus.busy); end
        next_cycle();
        idle();
        total++; if (bus.data_out !== 16'hBEEF) begin bad++; $display("FAIL al_data got=%h exp=BEEF", bus.data_out); end
`endif
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        rst         = 1'b1;
        bus.rd      = 1'b0;
        bus.wr      = 1'b0;
        bus.addr    = '0;
        bus.data_in = '0;
        test_reset();
        test_write_read();
        test_line_fill();
        test_conflict();
        test_err();
        test_align();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
